pipeline_stage_fetch: RTL and testbench
=======================================

Name: pipeline_stage_fetch

Overview:
- Stage 1 of the five-stage MIPS pipeline.
- Owns the program counter and issues in-order word fetches to instruction memory over a valid/ready request, valid-only response interface.
- Presents {programCounter, instruction, valid} in a registered output slot consumed combinationally by the decode stage.
- Honours the decode stall, and decode's jump redirect with one architectural delay slot.

Parameters:
- RESET_PC, 32'h0000_3000, address of the first fetch after reset.
- NOP_WORD, 32'h0000_0000, instruction presented when the output slot holds a bubble.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- stallOnDecode  in  1  decode (or later) stalled; output slot must hold
- jumpEnabled  in  1  decode redirects; only meaningful when fetchValid=1 and stallOnDecode=0
- jumpValue  in  32  redirect target, word aligned
- imemReqValid  out  1  request valid
- imemReqAddr  out  32  request word address
- imemReqReady  in  1  memory accepts request
- imemRespValid  in  1  response data valid; in order, one per accepted request, at least 1 cycle after acceptance
- imemRespData  in  32  fetched instruction
- fetchProgramCounter  out  32  PC of the instruction in the output slot
- fetchInstruction  out  32  instruction in the output slot (NOP_WORD when bubble)
- fetchValid  out  1  output slot holds a real instruction

Behaviour:
State:
- pcNext (32): next sequential address to request.
- outstanding (1): request accepted, response not yet received.
- bufValid/bufPc/bufInstr: one-entry skid buffer.
- redirectPending/redirectTarget.
- Invariant: outstanding + bufValid <= 1, so at most one instruction exists beyond the output slot.

Reset (synchronous):
- pcNext=RESET_PC.
- outstanding, bufValid, redirectPending, fetchValid = 0.
- fetchInstruction=NOP_WORD, fetchProgramCounter=0.
- imemReqValid=0 during the reset cycle.
- The memory shares this reset; responses seen during the reset cycle are dropped.

Request issue (combinational):
- imemReqValid = !bufValid && (!outstanding || (imemRespValid && !stallOnDecode)).
- imemReqAddr = jumpValue when jumpEnabled && fetchValid && !stallOnDecode && pcNext==fetchProgramCounter+8; otherwise pcNext.
- The redirect applies after the delay slot has already been issued.
- On handshake (imemReqValid && imemReqReady): outstanding<=1 and pcNext<=imemReqAddr+4, except when redirectPending, in which case pcNext<=redirectTarget and redirectPending<=0.

Response tracking:
- imemRespValid clears outstanding unless a new handshake occurs in the same cycle.
- imemRespValid with outstanding=0 is ignored.

Jump, case pcNext==fetchProgramCounter+4 (delay slot not yet issued):
- If the delay slot handshakes this cycle: pcNext<=jumpValue.
- Otherwise: redirectPending<=1 and redirectTarget<=jumpValue.
- The delay slot is always fetched before the target.
- A jump located in a delay slot is unsupported; behaviour is undefined.

Output slot (per edge, non-reset):
- stallOnDecode=0, priority order:
  1. bufValid: load buffer and clear bufValid.
  2. imemRespValid: load {PC of the outstanding request, imemRespData}. The outstanding PC is held in a reqPc register.
  3. Neither: bubble, with fetchValid=0, fetchInstruction=NOP_WORD, fetchProgramCounter unchanged.
- stallOnDecode=1: hold all outputs; an arriving response is written to the buffer (bufValid<=1).

Throughput and latency:
- With single-cycle memory and no stalls, one instruction per cycle.
- First valid output appears 2 cycles after reset deassertion: request in cycle 0, response in cycle 1, slot valid in cycle 2.

Reset mid-operation:
- Outstanding, buffer, redirect and slot state are all discarded.
- The next request is to RESET_PC.

Test Plan:
1. Reset, then 1-cycle memory, imemReqReady=1, no stalls → requests 0x3000,0x3004,0x3008… on consecutive cycles; fetchValid rises the 2nd cycle after reset with PC 0x3000, then PC increments by 4 each cycle.
2. stallOnDecode high for 3 cycles while the slot holds 0x3004 → outputs frozen; the 0x3008 response is buffered and no new request issues; on release the slot shows 0x3008 the next cycle and requests resume at 0x300C.
3. Branch at 0x3010 with jumpEnabled=1, jumpValue=0x3100, delay slot 0x3014 already outstanding → same-cycle request address is 0x3100; the slot sequence is 0x3010, 0x3014, 0x3100, 0x3104.
4. Same branch, but memory is 3-cycle with imemReqReady low when the jump fires → 0x3014 is issued later, followed by 0x3100 (redirectPending path); 0x3018 is never requested.
5. Memory latency 2 and imemReqReady toggling → bubbles appear (fetchValid=0, fetchInstruction=0); there are no duplicated or skipped PCs.
6. Reset asserted while a request is outstanding; the stale response arrives during reset → it is dropped; the first post-reset slot is PC 0x3000.

Source files
------------

// File: rtl/pipeline_stage_fetch.sv
// MIPS fetch stage: owns the PC, issues in-order word fetches, and feeds decode through a
// registered output slot backed by a one-entry skid buffer. Honours decode stall and delayed jumps.
module pipeline_stage_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stallOnDecode,
    input  logic        jumpEnabled,
    input  logic [31:0] jumpValue,
    output logic        imemReqValid,
    output logic [31:0] imemReqAddr,
    input  logic        imemReqReady,
    input  logic        imemRespValid,
    input  logic [31:0] imemRespData,
    output logic [31:0] fetchProgramCounter,
    output logic [31:0] fetchInstruction,
    output logic        fetchValid
);

    logic [31:0] pc_next_q, pc_next_d;
    logic        outstanding_q, outstanding_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        redirect_pending_q, redirect_pending_d;
    logic [31:0] redirect_target_q, redirect_target_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fetch_instr_q, fetch_instr_d;

    logic resp_ok;
    logic handshake;
    logic jump_fire;
    logic jump_early;
    logic jump_late;

    assign fetchValid          = fetch_valid_q;
    assign fetchProgramCounter = fetch_pc_q;
    assign fetchInstruction    = fetch_instr_q;

    always_comb begin
        pc_next_d          = pc_next_q;
        outstanding_d      = outstanding_q;
        req_pc_d           = req_pc_q;
        buf_valid_d        = buf_valid_q;
        buf_pc_d           = buf_pc_q;
        buf_instr_d        = buf_instr_q;
        redirect_pending_d = redirect_pending_q;
        redirect_target_d  = redirect_target_q;
        fetch_valid_d      = fetch_valid_q;
        fetch_pc_d         = fetch_pc_q;
        fetch_instr_d      = fetch_instr_q;

        resp_ok   = imemRespValid && outstanding_q;
        jump_fire = jumpEnabled && fetch_valid_q && !stallOnDecode;
        // early: delay slot not yet requested; late: delay slot already in flight or buffered
        jump_early = jump_fire && (pc_next_q == fetch_pc_q + 32'd4);
        jump_late  = jump_fire && (pc_next_q == fetch_pc_q + 32'd8);

        imemReqValid = !reset && !buf_valid_q &&
                       (!outstanding_q || (imemRespValid && !stallOnDecode));
        imemReqAddr  = jump_late ? jumpValue : pc_next_q;
        handshake    = imemReqValid && imemReqReady;

        if (resp_ok)
            outstanding_d = 1'b0;

        if (handshake) begin
            outstanding_d = 1'b1;
            req_pc_d      = imemReqAddr;
            if (redirect_pending_q) begin
                pc_next_d          = redirect_target_q;
                redirect_pending_d = 1'b0;
            end else if (jump_early) begin
                pc_next_d = jumpValue;
            end else begin
                pc_next_d = imemReqAddr + 32'd4;
            end
        end else if (jump_early) begin
            redirect_pending_d = 1'b1;
            redirect_target_d  = jumpValue;
        end else if (jump_late) begin
            // delay slot already fetched, so the target is simply the next address
            pc_next_d = jumpValue;
        end

        if (!stallOnDecode) begin
            if (buf_valid_q) begin
                fetch_valid_d = 1'b1;
                fetch_pc_d    = buf_pc_q;
                fetch_instr_d = buf_instr_q;
                buf_valid_d   = 1'b0;
            end else if (resp_ok) begin
                fetch_valid_d = 1'b1;
                fetch_pc_d    = req_pc_q;
                fetch_instr_d = imemRespData;
            end else begin
                fetch_valid_d = 1'b0;
                fetch_instr_d = NOP_WORD;
            end
        end else if (resp_ok) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = req_pc_q;
            buf_instr_d = imemRespData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_next_q          <= RESET_PC;
            outstanding_q      <= 1'b0;
            req_pc_q           <= 32'd0;
            buf_valid_q        <= 1'b0;
            buf_pc_q           <= 32'd0;
            buf_instr_q        <= NOP_WORD;
            redirect_pending_q <= 1'b0;
            redirect_target_q  <= 32'd0;
            fetch_valid_q      <= 1'b0;
            fetch_pc_q         <= 32'd0;
            fetch_instr_q      <= NOP_WORD;
        end else begin
            pc_next_q          <= pc_next_d;
            outstanding_q      <= outstanding_d;
            req_pc_q           <= req_pc_d;
            buf_valid_q        <= buf_valid_d;
            buf_pc_q           <= buf_pc_d;
            buf_instr_q        <= buf_instr_d;
            redirect_pending_q <= redirect_pending_d;
            redirect_target_q  <= redirect_target_d;
            fetch_valid_q      <= fetch_valid_d;
            fetch_pc_q         <= fetch_pc_d;
            fetch_instr_q      <= fetch_instr_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_fetch.sv
// Directed bench for pipeline_stage_fetch: per-cycle vector table plus jump, latency and reset sequences
// against a behavioural instruction memory with configurable latency.
module tb_pipeline_stage_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        jen = 1'b0;
    logic [31:0] jval = 32'd0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b1;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        f_valid;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipeline_stage_fetch dut (
        .clock(clock), .reset(reset), .stallOnDecode(stall),
        .jumpEnabled(jen), .jumpValue(jval),
        .imemReqValid(req_valid), .imemReqAddr(req_addr), .imemReqReady(req_ready),
        .imemRespValid(resp_valid), .imemRespData(resp_data),
        .fetchProgramCounter(f_pc), .fetchInstruction(f_instr), .fetchValid(f_valid)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // memory: one response, lat cycles after acceptance
    int          lat = 1;
    int          cnt = 0;
    logic        busy = 1'b0;
    logic [31:0] maddr = 32'd0;
    always @(posedge clock) begin
        if (reset) busy <= 1'b0;
        else if (req_valid && req_ready) begin
            busy <= 1'b1; cnt <= lat - 1; maddr <= req_addr;
        end else if (busy && cnt != 0) cnt <= cnt - 1;
        else busy <= 1'b0;
    end
    assign resp_valid = busy && (cnt == 0);
    assign resp_data  = resp_valid ? word_of(maddr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic        mon_en = 1'b0;
    logic [31:0] hs_q[$];
    logic [31:0] slot_q[$];
    int          bubbles = 0;
    always @(negedge clock) begin
        if (mon_en && !reset) begin
            if (req_valid && req_ready) hs_q.push_back(req_addr);
            if (f_valid) begin
                slot_q.push_back(f_pc);
                check("slot_instr", f_instr, word_of(f_pc));
            end else begin
                bubbles++;
                check("bubble_instr", f_instr, 32'h0);
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("rst_fetch_valid", 32'(f_valid), 32'd0);
        check("rst_fetch_pc", f_pc, 32'd0);
        check("rst_fetch_instr", f_instr, 32'd0);
    endtask

    task automatic step();
        @(negedge clock);
        @(posedge clock); #1;
    endtask

    typedef struct {
        logic        stall;
        logic        jen;
        logic [31:0] jval;
        logic        rv;
        logic [31:0] ra;
        logic        fv;
        logic [31:0] fpc;
    } vec_t;
    vec_t tv[14];

    initial begin
        // sequential run, stall on 0x3004, then jump at 0x3010 with delay slot in flight
        tv[0]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3000, 1'b0, 32'h0};
        tv[1]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3004, 1'b0, 32'h0};
        tv[2]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3008, 1'b1, 32'h3000};
        tv[3]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h3004};
        tv[4]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h3004};
        tv[5]  = '{1'b1, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h3004};
        tv[6]  = '{1'b0, 1'b0, 32'h0,    1'b0, 32'h0,    1'b1, 32'h3004};
        tv[7]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h300C, 1'b1, 32'h3008};
        tv[8]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3010, 1'b0, 32'h3008};
        tv[9]  = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3014, 1'b1, 32'h300C};
        tv[10] = '{1'b0, 1'b1, 32'h3100, 1'b1, 32'h3100, 1'b1, 32'h3010};
        tv[11] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3104, 1'b1, 32'h3014};
        tv[12] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h3108, 1'b1, 32'h3100};
        tv[13] = '{1'b0, 1'b0, 32'h0,    1'b1, 32'h310C, 1'b1, 32'h3104};

        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("req_valid_in_reset", 32'(req_valid), 32'd0);
            @(posedge clock); #1;
        end
        reset = 1'b0;
        check("rst_fetch_valid", 32'(f_valid), 32'd0);
        check("rst_fetch_instr", f_instr, 32'd0);

        for (int i = 0; i < 14; i++) begin
            stall = tv[i].stall; jen = tv[i].jen; jval = tv[i].jval;
            @(negedge clock);
            check($sformatf("v%0d_req_valid", i), 32'(req_valid), 32'(tv[i].rv));
            if (tv[i].rv) check($sformatf("v%0d_req_addr", i), req_addr, tv[i].ra);
            check($sformatf("v%0d_fetch_valid", i), 32'(f_valid), 32'(tv[i].fv));
            check($sformatf("v%0d_fetch_pc", i), f_pc, tv[i].fpc);
            check($sformatf("v%0d_fetch_instr", i), f_instr, tv[i].fv ? word_of(tv[i].fpc) : 32'h0);
            @(posedge clock); #1;
        end
        stall = 1'b0; jen = 1'b0;

        // jump with delay slot not yet issued because memory is not ready
        lat = 3; hs_q.delete(); slot_q.delete();
        do_reset();
        mon_en = 1'b1;
        for (int c = 0; c < 60; c++) begin
            jen  = f_valid && (f_pc == 32'h3010);
            jval = 32'h3100;
            req_ready = !((resp_valid && maddr == 32'h3010) || jen);
            step();
        end
        mon_en = 1'b0; jen = 1'b0; req_ready = 1'b1;
        begin
            logic [31:0] exp_hs[10];
            logic [31:0] exp_slot[9];
            int n3018;
            exp_hs   = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010,
                         32'h3014, 32'h3100, 32'h3104, 32'h3108, 32'h310C};
            exp_slot = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3010,
                         32'h3014, 32'h3100, 32'h3104, 32'h3108};
            check("t4_hs_count_ok", 32'(hs_q.size() >= 10), 32'd1);
            check("t4_slot_count_ok", 32'(slot_q.size() >= 9), 32'd1);
            for (int k = 0; k < 10 && k < hs_q.size(); k++)
                check($sformatf("t4_hs%0d", k), hs_q[k], exp_hs[k]);
            for (int k = 0; k < 9 && k < slot_q.size(); k++)
                check($sformatf("t4_slot%0d", k), slot_q[k], exp_slot[k]);
            n3018 = 0;
            foreach (hs_q[k]) if (hs_q[k] == 32'h3018) n3018++;
            check("t4_no_3018_request", 32'(n3018), 32'd0);
        end

        // latency 2 with ready toggling: bubbles, no duplicated or skipped PCs
        lat = 2; hs_q.delete(); slot_q.delete();
        do_reset();
        bubbles = 0; mon_en = 1'b1;
        for (int c = 0; c < 80; c++) begin
            req_ready = (c % 3) != 1;
            step();
        end
        mon_en = 1'b0; req_ready = 1'b1;
        check("t5_bubbles_seen", 32'(bubbles > 0), 32'd1);
        check("t5_slot_count_ok", 32'(slot_q.size() >= 10), 32'd1);
        foreach (slot_q[k]) check($sformatf("t5_slot%0d", k), slot_q[k], 32'h3000 + 32'(4 * k));
        foreach (hs_q[k]) check($sformatf("t5_hs%0d", k), hs_q[k], 32'h3000 + 32'(4 * k));

        // reset while 0x3008 is outstanding; its response lands in the reset cycle
        lat = 3;
        do_reset();
        begin
            bit found = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (resp_valid && maddr == 32'h3008) begin found = 1'b1; break; end
                step();
            end
            check("t6_stale_resp_reached", 32'(found), 32'd1);
        end
        reset = 1'b1;
        @(negedge clock);
        check("t6_req_valid_in_reset", 32'(req_valid), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        check("t6_fetch_valid_after_rst", 32'(f_valid), 32'd0);
        check("t6_fetch_pc_after_rst", f_pc, 32'd0);
        hs_q.delete(); slot_q.delete(); mon_en = 1'b1;
        repeat (12) step();
        mon_en = 1'b0;
        check("t6_slot_count_ok", 32'(slot_q.size() >= 1), 32'd1);
        check("t6_hs_count_ok", 32'(hs_q.size() >= 1), 32'd1);
        if (hs_q.size() > 0) check("t6_first_req", hs_q[0], 32'h3000);
        if (slot_q.size() > 0) check("t6_first_slot", slot_q[0], 32'h3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
